// File: rtl/ifns_decoder_7_deframer.sv
// ifns_decoder_7_deframer: decodes 7-bit IFNS codewords to 5-bit symbols and packs SYMS per word.
// Define IFNS_ERR_CHECK_EN to flag codewords whose weighted sum exceeds 31 on code_err.
module ifns_decoder_7_deframer #(
  parameter int SYMS = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [7:1]        code_in,
  input  logic              code_valid,
  input  logic              frame_start,
  output logic [5*SYMS-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overflow,
  output logic              code_err
);
  localparam int DATA_W = 5*SYMS;
  localparam int CW = $clog2(SYMS);
`ifdef IFNS_ERR_CHECK_EN
  localparam int SW = 6;
  logic s2_bad;
`else
  localparam int SW = 5;
`endif
  logic [7:1] s1_code;
  logic s1_valid, s1_fs;
  logic [SW-1:0] sum;
  logic [4:0] s2_sym;
  logic s2_valid, s2_fs;
  logic [CW-1:0] cnt, idx;
  logic [DATA_W-1:0] word, merged;
  logic done, load;
  assign sum = (s1_code[1] ? SW'(1) : SW'(0)) + (s1_code[2] ? SW'(1) : SW'(0))
             + (s1_code[3] ? SW'(2) : SW'(0)) + (s1_code[4] ? SW'(3) : SW'(0))
             + (s1_code[5] ? SW'(5) : SW'(0)) + (s1_code[6] ? SW'(8) : SW'(0))
             + (s1_code[7] ? SW'(13) : SW'(0));
  // frame_start restarts the word: slot 0 on a cleared base
  always_comb begin
    idx = s2_fs ? '0 : cnt;
    merged = s2_fs ? '0 : word;
    for (int k = 0; k < SYMS; k++)
      if (idx == CW'(k)) merged[5*k +: 5] = s2_sym;
    done = s2_valid && idx == CW'(SYMS-1);
    load = done && (!data_valid || data_ready);
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_code <= '0;
      s1_valid <= 1'b0;
      s1_fs <= 1'b0;
      s2_sym <= '0;
      s2_valid <= 1'b0;
      s2_fs <= 1'b0;
      cnt <= '0;
      word <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_code <= code_in;
      s1_valid <= code_valid;
      s1_fs <= frame_start;
      s2_sym <= sum[4:0];
      s2_valid <= s1_valid;
      s2_fs <= s1_fs;
      if (s2_valid) begin
        word <= done ? '0 : merged;
        cnt <= done ? '0 : idx + CW'(1);
      end
      if (load) begin
        data_out <= merged;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
      if (done && data_valid && !data_ready) overflow <= 1'b1;
    end
  end
`ifdef IFNS_ERR_CHECK_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s2_bad <= 1'b0;
      code_err <= 1'b0;
    end else begin
      s2_bad <= sum[5];
      if (s2_valid && s2_bad) code_err <= 1'b1;
    end
  end
`else
  assign code_err = 1'b0;
`endif
endmodule

// File: tb/tb_ifns_decoder_7_deframer.sv
// tb_ifns_decoder_7_deframer: directed checks of decode, packing, handshake, overflow and reset.
module tb_ifns_decoder_7_deframer;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [7:1] code_in = '0;
  logic code_valid = 1'b0;
  logic frame_start = 1'b0;
  logic [19:0] data_out;
  logic data_valid;
  logic data_ready = 1'b1;
  logic overflow;
  logic code_err;
  int pass = 0;
  int total = 0;
  localparam logic [6:0] C1 = 7'b0000001, C2 = 7'b0000100, C3 = 7'b0001000, C4 = 7'b0001001;
  localparam logic [6:0] C5 = 7'b0010000, C6 = 7'b0010001, CF = 7'b1111100, CX = 7'b1111111;
`ifdef IFNS_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  ifns_decoder_7_deframer #(.SYMS(4)) dut (
    .clock(clock), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .frame_start(frame_start), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .overflow(overflow), .code_err(code_err)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [6:0] c, input logic v, input logic f);
    @(negedge clock);
    code_in = c;
    code_valid = v;
    frame_start = f;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (data_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", data_valid); else pass++;
    total++; if (data_out !== 20'h0) $display("FAIL reset_data got %h want 00000", data_out); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass++;
    total++; if (code_err !== 1'b0) $display("FAIL reset_code_err got %b want 0", code_err); else pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [6:0] c;
    for (int i = 0; i < 8; i++) begin
      c = i == 0 ? C1 : i == 1 ? C2 : i == 2 ? C3 : C4;
      drive(c, i < 4, i == 0);
      total++; if (data_valid !== (i == 6)) $display("FAIL basic_valid[%0d] got %b want %b", i, data_valid, i == 6); else pass++;
      if (i == 6) begin
        total++; if (data_out !== 20'h20C41) $display("FAIL basic_data got %h want 20c41", data_out); else pass++;
      end
    end
    total++; if (overflow !== 1'b0) $display("FAIL basic_overflow got %b want 0", overflow); else pass++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) begin
      drive(i < 4 ? CF : 7'b0, i < 8, i == 0 || i == 4);
      total++; if (data_valid !== (i == 6 || i == 10)) $display("FAIL b2b_valid[%0d] got %b want %b", i, data_valid, i == 6 || i == 10); else pass++;
      if (i == 6) begin
        total++; if (data_out !== 20'hFFFFF) $display("FAIL b2b_data0 got %h want fffff", data_out); else pass++;
      end
      if (i == 10) begin
        total++; if (data_out !== 20'h00000) $display("FAIL b2b_data1 got %h want 00000", data_out); else pass++;
      end
    end
  endtask

  task automatic test_resync;
    logic [6:0] c;
    for (int i = 0; i < 10; i++) begin
      c = i == 0 ? C5 : i == 1 ? C6 : i == 2 ? C1 : i == 3 ? C2 : i == 4 ? C3 : C4;
      drive(c, i < 6, i == 0 || i == 2);
      total++; if (data_valid !== (i == 8)) $display("FAIL resync_valid[%0d] got %b want %b", i, data_valid, i == 8); else pass++;
      if (i == 8) begin
        total++; if (data_out !== 20'h20C41) $display("FAIL resync_data got %h want 20c41", data_out); else pass++;
      end
    end
  endtask

  task automatic test_code_err;
    logic [6:0] c;
    for (int i = 0; i < 8; i++) begin
      c = i == 0 ? CX : i == 1 ? C1 : i == 2 ? C2 : C3;
      drive(c, i < 4, i == 0);
      if (i == 6) begin
        total++; if (data_valid !== 1'b1) $display("FAIL err_valid got %b want 1", data_valid); else pass++;
        total++; if (data_out !== 20'h18821) $display("FAIL err_data got %h want 18821", data_out); else pass++;
        total++; if (code_err !== ERR_EXP) $display("FAIL err_flag got %b want %b", code_err, ERR_EXP); else pass++;
      end
    end
  endtask

  task automatic test_overflow;
    logic [6:0] c;
    data_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      c = i == 0 ? C1 : i == 1 ? C2 : i == 2 ? C3 : i == 3 ? C4 : C5;
      drive(c, i < 8, i == 0 || i == 4);
      if (i == 6 || i == 9) begin
        total++; if (overflow !== 1'b0) $display("FAIL ovf_early[%0d] got %b want 0", i, overflow); else pass++;
      end
      if (i == 6 || i == 11) begin
        total++; if (data_valid !== 1'b1) $display("FAIL ovf_valid[%0d] got %b want 1", i, data_valid); else pass++;
        total++; if (data_out !== 20'h20C41) $display("FAIL ovf_hold[%0d] got %h want 20c41", i, data_out); else pass++;
      end
      if (i == 11) begin
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass++;
        data_ready = 1'b1;
      end
      if (i == 12) begin
        total++; if (data_valid !== 1'b0) $display("FAIL ovf_drain got %b want 0", data_valid); else pass++;
      end
    end
  endtask

  task automatic test_reset_mid_word;
    logic [6:0] c;
    for (int i = 0; i < 3; i++) drive(C5, 1'b1, i == 0);
    drive(7'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (overflow !== 1'b0) $display("FAIL rst_mid_overflow got %b want 0", overflow); else pass++;
    total++; if (code_err !== 1'b0) $display("FAIL rst_mid_code_err got %b want 0", code_err); else pass++;
    total++; if (data_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", data_valid); else pass++;
    total++; if (data_out !== 20'h0) $display("FAIL rst_mid_data got %h want 00000", data_out); else pass++;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = i == 0 ? C1 : i == 1 ? C2 : i == 2 ? C3 : C4;
      drive(c, i < 4, 1'b0);
      total++; if (data_valid !== (i == 6)) $display("FAIL rst_new_valid[%0d] got %b want %b", i, data_valid, i == 6); else pass++;
      if (i == 6) begin
        total++; if (data_out !== 20'h20C41) $display("FAIL rst_new_data got %h want 20c41", data_out); else pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_resync;
    test_code_err;
    test_overflow;
    test_reset_mid_word;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
